// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port bundle: ALU writeback, long-latency results, issue reservations,
// decode busy queries and the merged register-file write.
interface wb_write_arbiter_if;
  logic        alu_we;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        lr_valid;
  logic        lr_ready;
  logic [4:0]  lr_waddr;
  logic [31:0] lr_wdata;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic [4:0]  q1_addr;
  logic [4:0]  q2_addr;
  logic        q1_busy;
  logic        q2_busy;
  logic        alu_stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Arbiter side
  modport slave (
    input  alu_we, alu_waddr, alu_wdata,
    input  lr_valid, lr_waddr, lr_wdata,
    input  iss_valid, iss_waddr,
    input  q1_addr, q2_addr,
    output lr_ready, q1_busy, q2_busy, alu_stall, rf_waddr, rf_wdata
  );

  // Pipeline / register-file side
  modport master (
    output alu_we, alu_waddr, alu_wdata,
    output lr_valid, lr_waddr, lr_wdata,
    output iss_valid, iss_waddr,
    output q1_addr, q2_addr,
    input  lr_ready, q1_busy, q2_busy, alu_stall, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges ALU writeback and FIFO-buffered long-latency results onto one register-file write port,
// with a pending-write scoreboard and starvation relief. Optional same-cycle bypass: WB_BYPASS_EN.
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  wb_write_arbiter_if.slave wb
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic             active_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ST_W-1:0]  starve_q, starve_d;
  logic [31:0]      sb_q, sb_d;

  logic [4:0]       mem_waddr [DEPTH];
  logic [31:0]      mem_wdata [DEPTH];

  logic             empty, full;
  logic             stall, alu_slot, pop, push, bypass, lr_ready;
  logic [4:0]       head_waddr;
  logic [31:0]      head_wdata;
  logic [4:0]       rf_waddr_c;
  logic [31:0]      rf_wdata_c;

  assign head_waddr = mem_waddr[rd_ptr_q];
  assign head_wdata = mem_wdata[rd_ptr_q];

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    // Forced drain slot once the FIFO has been blocked STARVE_LIMIT cycles in a row
    stall    = active_q && !empty && (starve_q == ST_W'(STARVE_LIMIT));
    alu_slot = active_q && wb.alu_we && (wb.alu_waddr != 5'd0) && !stall;
    pop      = active_q && !empty && !alu_slot;
`ifdef WB_BYPASS_EN
    bypass   = active_q && empty && !alu_slot && wb.lr_valid;
`else
    bypass   = 1'b0;
`endif
    lr_ready = active_q && (!full || bypass);
    push     = wb.lr_valid && lr_ready && !bypass;
  end

  always_comb begin
    rf_waddr_c = 5'd0;
    rf_wdata_c = 32'd0;
    if (alu_slot) begin
      rf_waddr_c = wb.alu_waddr;
      rf_wdata_c = wb.alu_wdata;
    end else if (pop) begin
      if (head_waddr != 5'd0) begin
        rf_waddr_c = head_waddr;
        rf_wdata_c = head_wdata;
      end
    end else if (bypass) begin
      if (wb.lr_waddr != 5'd0) begin
        rf_waddr_c = wb.lr_waddr;
        rf_wdata_c = wb.lr_wdata;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop)
      starve_d = '0;
    else if (!empty && alu_slot)
      starve_d = starve_q + ST_W'(1);
  end

  // Clear on retirement first so a same-cycle reservation of that register wins
  always_comb begin
    sb_d = sb_q;
    if (pop)    sb_d[head_waddr]  = 1'b0;
    if (bypass) sb_d[wb.lr_waddr] = 1'b0;
    if (active_q && wb.iss_valid) sb_d[wb.iss_waddr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      starve_q <= '0;
      sb_q     <= '0;
    end else begin
      active_q <= 1'b1;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      starve_q <= starve_d;
      sb_q     <= sb_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_waddr[wr_ptr_q] <= wb.lr_waddr;
      mem_wdata[wr_ptr_q] <= wb.lr_wdata;
    end
  end

  assign wb.lr_ready  = lr_ready;
  assign wb.alu_stall = stall;
  assign wb.rf_waddr  = rf_waddr_c;
  assign wb.rf_wdata  = rf_wdata_c;
  assign wb.q1_busy   = sb_q[wb.q1_addr];
  assign wb.q2_busy   = sb_q[wb.q2_addr];

endmodule
